// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding and
// the configuration legality check used at elaboration time.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic bit cfg_ok(int width, int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cbin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sd;
    logic             cbout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cbin, out_ready,
        input  in_ready, out_valid, sd, cbout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cbin, out_ready,
        output in_ready, out_valid, sd, cbout, ovf, zero
    );
endinterface

// File: rtl/addsub_chunk.sv
// C-bit ripple adder slice; also reports the carry into its MSB so the last
// slice can derive signed overflow.
module addsub_chunk #(
    parameter int C = 4
) (
    input  logic [C-1:0] i_a,
    input  logic [C-1:0] i_b,
    input  logic         i_ci,
    output logic [C-1:0] o_s,
    output logic         o_co,
    output logic         o_cm
);
    logic [C:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{C{1'b0}}, i_ci};
    assign o_s   = w_sum[C-1:0];
    assign o_co  = w_sum[C];
    // sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the sum
    assign o_cm  = i_a[C-1] ^ i_b[C-1] ^ w_sum[C-1];
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined N-bit adder/subtractor: one carry chunk resolved per stage,
// global stall when the output beat is not taken.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    addsub_pipe_if.slave  bus
);
    localparam int C = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("addsub_pipe: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic [STAGES-1:0]            r_vld, r_sub, r_c, r_cm;
    logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_sd;
    logic                         r_zero;

    logic [STAGES-1:0]            w_vld_in, w_sub_in, w_ci, w_co, w_cm;
    logic [STAGES-1:0][WIDTH-1:0] w_a_in, w_b_in, w_sd_in, w_sd_nx;
    logic [STAGES-1:0][C-1:0]     w_s;
    logic                         w_en;
    logic                         w_unused_bits;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // b is inverted once on entry; cbin ^ sub gives the effective carry-in
            assign w_vld_in[k] = bus.in_valid;
            assign w_sub_in[k] = (bus.sub == MODE_SUB);
            assign w_a_in[k]   = bus.a;
            assign w_b_in[k]   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            assign w_ci[k]     = bus.cbin ^ (bus.sub == MODE_SUB);
            assign w_sd_in[k]  = '0;
        end else begin : g_body
            assign w_vld_in[k] = r_vld[k-1];
            assign w_sub_in[k] = r_sub[k-1];
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_ci[k]     = r_c[k-1];
            assign w_sd_in[k]  = r_sd[k-1];
        end

        addsub_chunk #(.C(C)) u_chunk (
            .i_a  (w_a_in[k][k*C +: C]),
            .i_b  (w_b_in[k][k*C +: C]),
            .i_ci (w_ci[k]),
            .o_s  (w_s[k]),
            .o_co (w_co[k]),
            .o_cm (w_cm[k])
        );
    end

    always_comb begin
        w_sd_nx = w_sd_in;
        for (int k = 0; k < STAGES; k++) begin
            w_sd_nx[k][k*C +: C] = w_s[k];
        end
    end

    assign w_en = bus.out_ready | ~r_vld[L];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_sub  <= '0;
            r_c    <= '0;
            r_cm   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_sd   <= '0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            r_vld  <= w_vld_in;
            r_sub  <= w_sub_in;
            r_c    <= w_co;
            r_cm   <= w_cm;
            r_a    <= w_a_in;
            r_b    <= w_b_in;
            r_sd   <= w_sd_nx;
            r_zero <= (w_sd_nx[L] == '0);
        end
    end

    // Only the pending chunk of each operand copy is consumed downstream
    assign w_unused_bits = ^{r_a, r_b, r_cm};

    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_vld[L];
    assign bus.sd        = r_sd[L];
    assign bus.cbout     = r_c[L] ^ r_sub[L];
    assign bus.ovf       = r_c[L] ^ r_cm[L];
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: four configurations checked against an arithmetic
// reference model through a per-instance scoreboard.
module tb_addsub_pipe;

    typedef struct {
        logic [15:0] sd;
        logic        cb;
        logic        of;
        logic        z;
        int          en_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cfg_w [4] = '{4, 16, 16, 16};
    int cfg_s [4] = '{2, 4, 16, 1};

    logic        t_iv   [4];
    logic        t_ordy [4];
    logic        t_sub  [4];
    logic        t_cbin [4];
    logic [15:0] t_a    [4];
    logic [15:0] t_b    [4];
    logic        t_irdy [4];
    logic        t_ov   [4];
    logic        t_cb   [4];
    logic        t_of   [4];
    logic        t_z    [4];
    logic [15:0] t_sd   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GW = (g == 0) ? 4 : 16;
        localparam int GS = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 16 : 1;

        addsub_pipe_if #(.WIDTH(GW)) bus ();

        addsub_pipe #(.WIDTH(GW), .STAGES(GS)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        assign bus.in_valid  = t_iv[g];
        assign bus.out_ready = t_ordy[g];
        assign bus.sub       = t_sub[g];
        assign bus.cbin      = t_cbin[g];
        assign bus.a         = t_a[g][GW-1:0];
        assign bus.b         = t_b[g][GW-1:0];
        assign t_irdy[g]     = bus.in_ready;
        assign t_ov[g]       = bus.out_valid;
        assign t_cb[g]       = bus.cbout;
        assign t_of[g]       = bus.ovf;
        assign t_z[g]        = bus.zero;
        assign t_sd[g]       = 16'(bus.sd);
    end

    int   ntests = 0;
    int   nfail  = 0;
    int   edge_cnt = 0;
    int   n_out [4] = '{0, 0, 0, 0};
    bit   chk_lat = 1'b0;
    exp_t q [4][$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic s, logic c);
        exp_t   e;
        longint m, ua, ub, sa, sb, r, sr;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            r    = ua - ub - longint'(c);
            sr   = sa - sb - longint'(c);
            e.cb = (r < 0);
        end else begin
            r    = ua + ub + longint'(c);
            sr   = sa + sb + longint'(c);
            e.cb = (r >= m);
        end
        r         = ((r % m) + m) % m;
        e.sd      = 16'(r);
        e.of      = (sr < -(m / 2)) || (sr >= m / 2);
        e.z       = (r == 0);
        e.en_edge = 0;
        return e;
    endfunction

    // One clock: score consumed/accepted beats just before the edge, sample after it
    task automatic tick();
        logic rr;
        exp_t e;
        #1;
        rr = rst_n;
        if (rr) begin
            for (int d = 0; d < 4; d++) begin
                if (t_ov[d] && t_ordy[d]) begin
                    chk($sformatf("d%0d_beat_expected", d), 32'(q[d].size() > 0), 1);
                    if (q[d].size() > 0) begin
                        e = q[d].pop_front();
                        n_out[d]++;
                        chk($sformatf("d%0d_sd", d), 32'(t_sd[d]), 32'(e.sd));
                        chk($sformatf("d%0d_cbout", d), 32'(t_cb[d]), 32'(e.cb));
                        chk($sformatf("d%0d_ovf", d), 32'(t_of[d]), 32'(e.of));
                        chk($sformatf("d%0d_zero", d), 32'(t_z[d]), 32'(e.z));
                        if (chk_lat)
                            chk($sformatf("d%0d_latency", d), 32'(edge_cnt + 1 - e.en_edge), 32'(cfg_s[d]));
                    end
                end
                if (t_iv[d] && t_irdy[d]) begin
                    e = model(cfg_w[d], t_a[d], t_b[d], t_sub[d], t_cbin[d]);
                    e.en_edge = edge_cnt + 1;
                    q[d].push_back(e);
                end
            end
        end
        @(posedge clk);
        edge_cnt++;
        if (!rr) begin
            for (int d = 0; d < 4; d++) q[d].delete();
        end
        #1;
    endtask

    task automatic drive(int d, logic iv, logic [15:0] a, logic [15:0] b, logic s, logic c);
        logic [15:0] m;
        m         = 16'((32'd1 << cfg_w[d]) - 1);
        t_iv[d]   = iv;
        t_a[d]    = a & m;
        t_b[d]    = b & m;
        t_sub[d]  = s;
        t_cbin[d] = c;
    endtask

    task automatic drive_rand(int d, logic iv);
        drive(d, iv, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic directed(int d, string tag, logic [15:0] a, logic [15:0] b, logic s, logic c,
                            logic [15:0] esd, logic ecb, logic eof, logic ez);
        drive(d, 1'b1, a, b, s, c);
        tick();
        t_iv[d] = 1'b0;
        repeat (cfg_s[d] - 1) tick();
        chk($sformatf("%s_valid", tag), 32'(t_ov[d]), 1);
        chk($sformatf("%s_sd", tag), 32'(t_sd[d]), 32'(esd));
        chk($sformatf("%s_cbout", tag), 32'(t_cb[d]), 32'(ecb));
        chk($sformatf("%s_ovf", tag), 32'(t_of[d]), 32'(eof));
        chk($sformatf("%s_zero", tag), 32'(t_z[d]), 32'(ez));
        tick();
    endtask

    task automatic drain();
        int guard;
        bit busy;
        for (int d = 0; d < 4; d++) begin
            t_iv[d]   = 1'b0;
            t_ordy[d] = 1'b1;
        end
        guard = 0;
        busy  = 1'b1;
        while (busy && guard < 80) begin
            tick();
            guard++;
            busy = 1'b0;
            for (int d = 0; d < 4; d++) if (q[d].size() > 0) busy = 1'b1;
        end
        chk("drain_complete", 32'(busy), 0);
    endtask

    initial begin
        int base;
        for (int d = 0; d < 4; d++) begin
            t_ordy[d] = 1'b1;
            drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        end

        rst_n = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("d%0d_rst_out_valid", d), 32'(t_ov[d]), 0);
            chk($sformatf("d%0d_rst_in_ready", d), 32'(t_irdy[d]), 1);
            chk($sformatf("d%0d_rst_sd", d), 32'(t_sd[d]), 0);
            chk($sformatf("d%0d_rst_cbout", d), 32'(t_cb[d]), 0);
            chk($sformatf("d%0d_rst_ovf", d), 32'(t_of[d]), 0);
            chk($sformatf("d%0d_rst_zero", d), 32'(t_z[d]), 0);
        end
        rst_n = 1'b1;
        tick();

        chk_lat = 1'b1;
        directed(0, "w4_add", 16'h6, 16'h5, 1'b0, 1'b1, 16'hC, 1'b0, 1'b1, 1'b0);
        directed(0, "w4_sub_neg", 16'h5, 16'h6, 1'b1, 1'b0, 16'hF, 1'b1, 1'b0, 1'b0);
        directed(0, "w4_sub_zero", 16'hF, 16'hF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int d = 1; d < 4; d++) begin
            directed(d, $sformatf("d%0d_wrap_add", d), 16'hFFFF, 16'h0001, 1'b0, 1'b0,
                     16'h0000, 1'b1, 1'b0, 1'b1);
            directed(d, $sformatf("d%0d_ovf_sub", d), 16'h8000, 16'h0001, 1'b1, 1'b0,
                     16'h7FFF, 1'b0, 1'b1, 1'b0);
        end

        // full-rate stream on the 16/4 instance
        base = n_out[1];
        for (int i = 0; i < 100; i++) begin
            drive_rand(1, 1'b1);
            #1;
            chk("stream_in_ready", 32'(t_irdy[1]), 1);
            tick();
        end
        drain();
        chk("stream_count", 32'(n_out[1] - base), 100);

        // backpressure with the pipe full
        chk_lat = 1'b0;
        base = n_out[1];
        for (int i = 0; i < 6; i++) begin
            drive_rand(1, 1'b1);
            tick();
        end
        t_ordy[1] = 1'b0;
        drive_rand(1, 1'b1);
        #1;
        chk("stall_in_ready", 32'(t_irdy[1]), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_in_ready_hold", 32'(t_irdy[1]), 0);
            chk("stall_out_valid", 32'(t_ov[1]), 1);
            chk("stall_sd", 32'(t_sd[1]), (q[1].size() > 0) ? 32'(q[1][0].sd) : 32'hFFFF_FFFF);
        end
        drain();
        chk("stall_count", 32'(n_out[1] - base), 6);

        // reset with three beats in flight
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1, 1'b1);
            tick();
        end
        t_iv[1] = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(t_ov[1]), 0);
        chk("midrst_sd", 32'(t_sd[1]), 0);
        chk("midrst_in_ready", 32'(t_irdy[1]), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_stale", 32'(t_ov[1]), 0);
        end

        // random traffic with random backpressure on every configuration
        chk_lat = 1'b0;
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 4; d++) begin
                t_ordy[d] = ($urandom_range(0, 3) != 0);
                drive_rand(d, 1'($urandom_range(0, 1)));
            end
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake and per-operation add/subtract select. The carry chain is split into STAGES equal chunks, one chunk resolved per cycle, giving a fixed STAGES-cycle latency and one result per clock at full throughput. It replaces the fixed 4-bit combinational adder-cum-subtractor wherever wide operands or a registered, flow-controlled result are needed. Outputs are carry/borrow, signed overflow and zero flags.

## Interface
- WIDTH, 16, operand/result width in bits (≥ 2)
- STAGES, 4, pipeline depth = number of carry chunks; WIDTH % STAGES == 0 and 1 ≤ STAGES ≤ WIDTH
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  minuend / addend
- b  input  WIDTH  subtrahend / addend
- sub  input  1  0 = add, 1 = subtract
- cbin  input  1  carry-in (add) or borrow-in (subtract)
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- sd  output  WIDTH  sum / difference
- cbout  output  1  carry-out (add) or borrow-out (subtract)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sd == 0

## Operation
- Add: {cbout, sd} = a + b + cbin.
- Subtract: internally a + ~b + ~cbin; sd = a − b − cbin mod 2^WIDTH; cbout = NOT(internal carry) = 1 when a < b + cbin (unsigned borrow).
- ovf = carry into MSB XOR carry out of MSB (internal, before borrow inversion); valid for both modes.
- zero computed from the final sd in the last stage.
- Chunk width C = WIDTH/STAGES. Stage k (0-based) adds bits [k·C +: C] of a and effective b with the carry from stage k−1; stage 0 uses the effective carry-in. Unprocessed operand bits travel with the beat; already-resolved sum bits are carried forward. sub travels with the beat (for cbout inversion).
- Each stage register holds a valid bit; beats never reorder, merge or drop.
- Flow control: global advance enable en = out_ready OR NOT out_valid. in_ready = en. A beat is accepted when in_valid AND in_ready. When en = 0 every stage holds (including bubbles). When en = 1 each stage loads from its predecessor; stage 0 loads the input beat with valid = in_valid.
- Output registers hold value stable while out_valid AND NOT out_ready.
- STAGES = 1: single registered adder, same handshake.

## Timing
- Reset (rst_n low at a clk edge): all stage valid bits 0 → out_valid = 0, in_ready = 1 next cycle; sd = 0, cbout = 0, ovf = 0, zero = 0. Data registers other than outputs may be left unreset.
- Reset mid-operation: all in-flight beats discarded; no partial result ever appears.
- Latency: beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1 (i.e. visible in cycle n+STAGES when counting acceptance edge as cycle 1 of STAGES), assuming no stall.
- Throughput: one beat/cycle while out_ready = 1.
- Stall: out_ready low with out_valid high freezes the whole pipe the same cycle (in_ready low combinationally); releasing out_ready resumes with no loss or duplication.
- in_ready depends combinationally on out_ready and out_valid only; no path from in_valid to in_ready.
- Wrap-around: results are modulo 2^WIDTH; overflow is only flagged, never saturated.

## Structure
- Shared package addsub_pkg: mode encoding constants (ADD = 0, SUB = 1) and the elaboration-time check WIDTH % STAGES == 0.
- One sub-module addsub_chunk: C-bit combinational ripple adder with carry-in, carry-out and carry-into-MSB outputs; instantiated STAGES times via generate, with stage registers in addsub_pipe.

## Test plan
- WIDTH=4, STAGES=2, add: a=0110, b=0101, cbin=1 → sd=1100, cbout=0, ovf=1, zero=0 two cycles after acceptance.
- WIDTH=4, STAGES=2, subtract: a=0101, b=0110, cbin=0 → sd=1111, cbout=1, ovf=0; a=1111, b=1111, cbin=0 → sd=0000, cbout=0, zero=1.
- WIDTH=16, STAGES=4, back-to-back stream of 100 random beats with out_ready=1 → 100 results in order, one per cycle, all matching a reference model; first result 4 cycles after first acceptance.
- Backpressure: hold out_ready low for 5 cycles with the pipe full → in_ready=0, sd/out_valid stable; after release, no beat lost or duplicated.
- Reset mid-stream: assert rst_n=0 for one edge with 3 beats in flight → next cycle out_valid=0, sd=0, in_ready=1; no stale beat emerges afterwards.
- Edge values WIDTH=16, STAGES=16 and STAGES=1: a=FFFF, b=0001, add → sd=0000, cbout=1, zero=1, ovf=0; a=8000, b=0001, sub → sd=7FFF, ovf=1, cbout=0.
